writeback_sequencer: RTL and testbench

WRITEBACK_SEQUENCER -- requirements
Module: writeback_sequencer

---
 rtl/writeback_sequencer.sv | 114 +++++++++++
 tb/tb_writeback_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_sequencer.sv
// rtl/writeback_sequencer.sv - retires one instruction at a time into the register file,
// waiting (bounded) for load data when the result comes from memory.
module writeback_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        inValid,
    output logic        inReady,
    input  logic        inRegWrite,
    input  logic        inMemToReg,
    input  logic [4:0]  inDestReg,
    input  logic [63:0] inAluResult,
    input  logic        memDataValid,
    input  logic [63:0] memReadData,
    output logic [4:0]  writeAddress,
    output logic [63:0] writeData,
    output logic        regWrite,
    output logic        memError,
    output logic [31:0] retireCount
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [4:0]    XZR       = 5'd31;

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t        state_q, state_d;
    logic          cap_rw_q, cap_rw_d;
    logic [4:0]    dest_q, dest_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [4:0]    addr_q, addr_d;
    logic [63:0]   data_q, data_d;
    logic          mem_error_q, mem_error_d;
    logic [31:0]   retire_q, retire_d;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cap_rw_q    <= 1'b0;
            dest_q      <= '0;
            wait_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mem_error_q <= 1'b0;
            retire_q    <= '0;
        end else begin
            state_q     <= state_d;
            cap_rw_q    <= cap_rw_d;
            dest_q      <= dest_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            mem_error_q <= mem_error_d;
            retire_q    <= retire_d;
        end
    end

    // Write outputs only change on entry to WRITE, so a pending load leaves the last write visible.
    always_comb begin
        state_d     = state_q;
        cap_rw_d    = cap_rw_q;
        dest_d      = dest_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        data_d      = data_q;
        mem_error_d = mem_error_q;
        retire_d    = retire_q;
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    cap_rw_d = inRegWrite;
                    dest_d   = inDestReg;
                    wait_d   = '0;
                    if (inMemToReg) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d = WRITE;
                        addr_d  = inDestReg;
                        data_d  = inAluResult;
                    end
                end
            end
            WAIT_MEM: begin
                // Data on the final allowed cycle still wins over the timeout.
                if (memDataValid) begin
                    state_d = WRITE;
                    addr_d  = dest_q;
                    data_d  = memReadData;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WAIT_LAST) begin
                        mem_error_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            WRITE: begin
                state_d  = IDLE;
                retire_d = retire_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign inReady      = (state_q == IDLE);
    assign regWrite     = (state_q == WRITE) && cap_rw_q && (dest_q != XZR);
    assign writeAddress = addr_q;
    assign writeData    = data_q;
    assign memError     = mem_error_q;
    assign retireCount  = retire_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
// tb/tb_writeback_sequencer.sv - directed and random instructions checked against a
// transaction-level expectation of each retirement.
module tb_writeback_sequencer;

    localparam int MEM_TIMEOUT = 15;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        inValid, inReady, inRegWrite, inMemToReg;
    logic [4:0]  inDestReg;
    logic [63:0] inAluResult;
    logic        memDataValid;
    logic [63:0] memReadData;
    logic [4:0]  writeAddress;
    logic [63:0] writeData;
    logic        regWrite, memError;
    logic [31:0] retireCount;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_retire;
    logic        exp_err;
    logic [4:0]  last_addr;
    logic [63:0] last_data;

    writeback_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .inValid(inValid), .inReady(inReady),
        .inRegWrite(inRegWrite), .inMemToReg(inMemToReg),
        .inDestReg(inDestReg), .inAluResult(inAluResult),
        .memDataValid(memDataValid), .memReadData(memReadData),
        .writeAddress(writeAddress), .writeData(writeData),
        .regWrite(regWrite), .memError(memError), .retireCount(retireCount)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_ready, input logic exp_we);
        check({tag, ".inReady"}, 64'(inReady), 64'(exp_ready));
        check({tag, ".regWrite"}, 64'(regWrite), 64'(exp_we));
        check({tag, ".writeAddress"}, 64'(writeAddress), 64'(last_addr));
        check({tag, ".writeData"}, writeData, last_data);
        check({tag, ".memError"}, 64'(memError), 64'(exp_err));
        check({tag, ".retireCount"}, 64'(retireCount), 64'(exp_retire));
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic model_reset();
        exp_retire = '0;
        exp_err    = 1'b0;
        last_addr  = '0;
        last_data  = '0;
    endtask

    // lat = WAIT_MEM cycle (1-based) in which load data shows up; 0 = never.
    task automatic run_instr(input logic rw, input logic m2r, input logic [4:0] dest,
                             input logic [63:0] alu, input int lat, input logic [63:0] mdata);
        logic we;
        logic done;
        we           = rw && (dest != 5'd31);
        done         = 1'b0;
        inValid      = 1'b1;
        inRegWrite   = rw;
        inMemToReg   = m2r;
        inDestReg    = dest;
        inAluResult  = alu;
        memDataValid = 1'($urandom_range(0, 1));
        memReadData  = {$urandom, $urandom};
        step();
        inValid      = 1'b0;
        memDataValid = 1'b0;
        if (!m2r) begin
            last_addr = dest;
            last_data = alu;
            check_outputs("alu_write", 1'b0, we);
            step();
            exp_retire = exp_retire + 32'd1;
            check_outputs("alu_done", 1'b1, 1'b0);
        end else begin
            for (int k = 1; k <= MEM_TIMEOUT && !done; k++) begin
                check_outputs("load_wait", 1'b0, 1'b0);
                memDataValid = (k == lat);
                memReadData  = (k == lat) ? mdata : {$urandom, $urandom};
                step();
                memDataValid = 1'b0;
                if (k == lat) begin
                    done      = 1'b1;
                    last_addr = dest;
                    last_data = mdata;
                    check_outputs("load_write", 1'b0, we);
                    step();
                    exp_retire = exp_retire + 32'd1;
                    check_outputs("load_done", 1'b1, 1'b0);
                end
            end
            if (!done) begin
                exp_err = 1'b1;
                check_outputs("timeout", 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        int          lat;

        RESET        = 1'b1;
        inValid      = 1'b0;
        inRegWrite   = 1'b0;
        inMemToReg   = 1'b0;
        inDestReg    = '0;
        inAluResult  = '0;
        memDataValid = 1'b0;
        memReadData  = '0;
        model_reset();
        #12;
        check_outputs("reset", 1'b1, 1'b0);
        @(negedge CLOCK);
        RESET = 1'b0;
        step();
        check_outputs("post_reset", 1'b1, 1'b0);

        run_instr(1'b1, 1'b0, 5'd5, 64'h2A, 0, 64'h0);
        run_instr(1'b1, 1'b1, 5'd3, 64'h1234, 4, 64'hDEAD);
        run_instr(1'b1, 1'b0, 5'd31, 64'h77, 0, 64'h0);
        run_instr(1'b0, 1'b0, 5'd9, 64'h55, 0, 64'h0);
        run_instr(1'b1, 1'b1, 5'd31, 64'h0, 2, 64'hBEEF);
        run_instr(1'b1, 1'b1, 5'd7, 64'h0, 1, 64'hCAFE);
        run_instr(1'b1, 1'b1, 5'd8, 64'h0, MEM_TIMEOUT, 64'hF00D);

        // Back-to-back: inValid stays high across two ALU ops.
        inValid = 1'b1; inRegWrite = 1'b1; inMemToReg = 1'b0;
        inDestReg = 5'd10; inAluResult = 64'h111;
        step();
        last_addr = 5'd10; last_data = 64'h111;
        check_outputs("b2b_first", 1'b0, 1'b1);
        inDestReg = 5'd11; inAluResult = 64'h222;
        step();
        exp_retire = exp_retire + 32'd1;
        check_outputs("b2b_gap", 1'b1, 1'b0);
        step();
        inValid = 1'b0;
        last_addr = 5'd11; last_data = 64'h222;
        check_outputs("b2b_second", 1'b0, 1'b1);
        step();
        exp_retire = exp_retire + 32'd1;
        check_outputs("b2b_done", 1'b1, 1'b0);

        run_instr(1'b1, 1'b1, 5'd12, 64'h0, 0, 64'h0);
        run_instr(1'b1, 1'b0, 5'd13, 64'h99, 0, 64'h0);

        for (int i = 0; i < 40; i++) begin
            a   = {$urandom, $urandom};
            d   = {$urandom, $urandom};
            lat = int'($urandom_range(1, MEM_TIMEOUT + 2));
            if (lat > MEM_TIMEOUT) lat = 0;
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 31)), a, lat, d);
        end

        // Reset while waiting for load data, then late data must be ignored.
        inValid = 1'b1; inRegWrite = 1'b1; inMemToReg = 1'b1; inDestReg = 5'd4;
        step();
        inValid = 1'b0;
        step();
        step();
        RESET = 1'b1;
        #1;
        model_reset();
        check_outputs("reset_in_wait", 1'b1, 1'b0);
        #1;
        RESET = 1'b0;
        memDataValid = 1'b1;
        memReadData  = 64'h1357;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outputs("reset_late_data", 1'b1, 1'b0);
        end
        memDataValid = 1'b0;

        // Reset during the WRITE cycle.
        inValid = 1'b1; inRegWrite = 1'b1; inMemToReg = 1'b0;
        inDestReg = 5'd6; inAluResult = 64'h66;
        step();
        inValid = 1'b0;
        RESET = 1'b1;
        #1;
        check_outputs("reset_in_write", 1'b1, 1'b0);
        #1;
        RESET = 1'b0;
        step();
        check_outputs("after_write_reset", 1'b1, 1'b0);

        run_instr(1'b1, 1'b0, 5'd1, 64'hABCD, 0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
